// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions for the transmit encoder and the receive-side syndrome checker.
package hamming_pkg;

    localparam int K_DEF = 4;
    localparam int N_DEF = 7;
    localparam int M_DEF = 3;

    typedef logic [K_DEF-1:0] g_matrix_t [N_DEF-1:0];
    typedef logic [N_DEF-1:0] h_matrix_t [M_DEF-1:0];

    // Leftmost entry is row N-1; row r selects the data bits XORed into codeword bit r.
    localparam g_matrix_t G_DEF = '{4'b1000, 4'b0100, 4'b0010, 4'b1110, 4'b0001, 4'b1101, 4'b1011};

    // Column i holds the binary Hamming position i+1, so a single-bit error's syndrome names its position.
    localparam h_matrix_t H_DEF = '{7'b1111000, 7'b1100110, 7'b1010101};

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

endpackage

// File: rtl/hamming_gen_mod2.sv
// Combinational generator-matrix product cw = G*d mod 2.
module hamming_gen_mod2
    import hamming_pkg::*;
#(
    parameter int K = K_DEF,
    parameter int N = N_DEF,
    parameter logic [K-1:0] G [N-1:0] = G_DEF
) (
    input  logic [K-1:0] data,
    output logic [N-1:0] cw
);

    always_comb begin
        cw = '0;
        for (int r = 0; r < N; r++) begin
            cw[r] = ^(G[r] & data);
        end
    end

endmodule

// File: rtl/hamming_encoder_tx.sv
// Hamming encoder with LSB-first serializer; define SECDED_EN to append an overall even-parity bit.
module hamming_encoder_tx
    import hamming_pkg::*;
#(
    parameter int K = K_DEF,
    parameter int N = N_DEF,
    parameter logic [K-1:0] G [N-1:0] = G_DEF,
`ifdef SECDED_EN
    localparam int N_OUT = N + 1
`else
    localparam int N_OUT = N
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [K-1:0]     in_data,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_data,
    output logic             ser_last,
    output logic [N_OUT-1:0] cw_out,
    output logic             cw_strobe
);

    localparam int CW = $clog2(N_OUT + 1);

    state_t           state;
    state_t           next_state;
    logic [CW-1:0]    cnt;
    logic [N_OUT-1:0] shreg;
    logic [N-1:0]     cw;
    logic [N_OUT-1:0] cw_full;
    logic             accept;
    logic             xfer;

    hamming_gen_mod2 #(
        .K(K),
        .N(N),
        .G(G)
    ) u_gen (
        .data(in_data),
        .cw  (cw)
    );

`ifdef SECDED_EN
    assign cw_full = {^cw, cw};
`else
    assign cw_full = cw;
`endif

    // in_ready is gated by rst_n so no word can be taken while reset is held.
    always_comb begin
        in_ready   = 1'b0;
        ser_valid  = 1'b0;
        ser_data   = 1'b0;
        ser_last   = 1'b0;
        next_state = state;
        if (state == IDLE) begin
            in_ready = rst_n;
        end else begin
            ser_valid = 1'b1;
            ser_data  = shreg[0];
            ser_last  = (cnt == CW'(N_OUT - 1));
        end
        accept = in_valid & in_ready;
        xfer   = ser_valid & ser_ready;
        case (state)
            IDLE:    if (accept) next_state = SHIFT;
            SHIFT:   if (xfer && ser_last) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            cw_out    <= '0;
            cw_strobe <= 1'b0;
        end else begin
            state     <= next_state;
            cw_strobe <= 1'b0;
            if (accept) begin
                shreg     <= cw_full;
                cw_out    <= cw_full;
                cw_strobe <= 1'b1;
                cnt       <= '0;
            end else if (xfer) begin
                shreg <= shreg >> 1;
                cnt   <= ser_last ? '0 : cnt + CW'(1);
            end
        end
    end

endmodule
